jt1943_rom_arbiter: RTL and testbench

Shares the single SDRAM read port (jtgng_sdram read_req/sdram_ack/data_rdy) among SLOTS ROM requesters inside jt1943_game: main CPU, sound CPU, char, scroll and object fetchers. Each slot has a one-entry cache: a repeat address hits without touching SDRAM, and a miss is scheduled round-robin. The block gates refresh so refresh happens only when the port is idle. It holds off all traffic during ROM download or SDRAM init loop.

---
 rtl/jt1943_rom_pkg.sv | 18 +
 rtl/jt1943_rr_pick.sv | 29 ++
 rtl/jt1943_rom_arbiter.sv | 133 +++++++++++++
 tb/tb_jt1943_rom_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jt1943_rom_pkg.sv
// Shared constants and FSM encoding for the jt1943 ROM read-port arbiter.
package jt1943_rom_pkg;

  localparam int unsigned DEF_AW = 22;
  localparam int unsigned DEF_DW = 32;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_ACK  = 2'd1;
  localparam logic [1:0] ST_WAIT_DATA = 2'd2;

  // Slot index width; never narrower than one bit.
  function automatic int unsigned slot_iw(input int unsigned slots);
    return (slots > 1) ? $clog2(slots) : 1;
  endfunction

endpackage

// File: rtl/jt1943_rr_pick.sv
// Round-robin picker: first pending slot searching upward from ptr+1, wrapping.
module jt1943_rr_pick
  import jt1943_rom_pkg::*;
#(
  parameter int unsigned SLOTS = 4,
  parameter int unsigned IW    = slot_iw(SLOTS)
) (
  input  logic [SLOTS-1:0] pend,
  input  logic [IW-1:0]    ptr,
  output logic             any,
  output logic [IW-1:0]    idx
);

  int unsigned cand;

  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = 0;
    for (int unsigned k = 1; k <= SLOTS; k++) begin
      cand = (32'(ptr) + k) % SLOTS;
      if (!any && pend[IW'(cand)]) begin
        any = 1'b1;
        idx = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/jt1943_rom_arbiter.sv
// Shares the SDRAM read port among ROM requesters, each with a one-entry cache;
// misses are fetched round-robin and refresh is allowed only while idle.
module jt1943_rom_arbiter
  import jt1943_rom_pkg::*;
#(
  parameter int unsigned SLOTS = 4,
  parameter int unsigned AW    = DEF_AW,
  parameter int unsigned DW    = DEF_DW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SLOTS-1:0]    slot_req,
  input  logic [SLOTS*AW-1:0] slot_addr,
  output logic [SLOTS-1:0]    slot_ok,
  output logic [SLOTS*DW-1:0] slot_dout,
  input  logic                downloading,
  input  logic                loop_rst,
  output logic                sdram_req,
  output logic [AW-1:0]       sdram_addr,
  input  logic                sdram_ack,
  input  logic                data_rdy,
  input  logic [DW-1:0]       data_read,
  output logic                refresh_en
);

  localparam int unsigned IW = slot_iw(SLOTS);

  state_t          state, state_nx;
  logic [IW-1:0]   sel, ptr, pick_idx;
  logic            pick_any;
  logic [SLOTS-1:0] valid, hit, pend;
  logic [AW-1:0]   cache_addr [SLOTS];
  logic [AW-1:0]   req_addr   [SLOTS];
  logic            hold, issue, fill, req_clr;

  // Per-slot hit detection against the one-entry caches.
  always_comb begin
    for (int unsigned i = 0; i < SLOTS; i++) begin
      req_addr[i] = slot_addr[i*AW +: AW];
      hit[i]      = valid[i] & (cache_addr[i] == req_addr[i]);
    end
  end

  assign slot_ok = slot_req & hit;
  assign pend    = slot_req & ~hit;
  assign hold    = downloading | loop_rst;

  jt1943_rr_pick #(.SLOTS(SLOTS), .IW(IW)) u_pick (
    .pend (pend),
    .ptr  (ptr),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next state; ack and data in the same WAIT_ACK cycle count as both events.
  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    fill     = 1'b0;
    req_clr  = 1'b0;
    if (hold) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            issue    = 1'b1;
            state_nx = ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (sdram_ack) begin
            req_clr  = 1'b1;
            fill     = data_rdy;
            state_nx = data_rdy ? ST_IDLE : ST_WAIT_DATA;
          end
        end
        ST_WAIT_DATA: begin
          if (data_rdy) begin
            fill     = 1'b1;
            state_nx = ST_IDLE;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // Request, pointer and valid bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      refresh_en <= 1'b1;
      sel        <= '0;
      ptr        <= IW'(SLOTS - 1);
      valid      <= '0;
    end else if (hold) begin
      sdram_req  <= 1'b0;
      refresh_en <= 1'b1;
      valid      <= '0;
    end else begin
      if (issue) begin
        sel        <= pick_idx;
        ptr        <= pick_idx;
        sdram_addr <= req_addr[pick_idx];
        sdram_req  <= 1'b1;
        refresh_en <= 1'b0;
      end else if (state == ST_IDLE) begin
        refresh_en <= 1'b1;
      end
      if (req_clr) sdram_req <= 1'b0;
      if (fill)    valid[sel] <= 1'b1;
    end
  end

  // Fill stores the latched fetch address, not the slot's current one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SLOTS; i++) cache_addr[i] <= '0;
      slot_dout <= '0;
    end else if (fill) begin
      cache_addr[sel]            <= sdram_addr;
      slot_dout[32'(sel)*DW +: DW] <= data_read;
    end
  end

endmodule

// File: tb/tb_jt1943_rom_arbiter.sv
// Directed and randomized checks of the ROM arbiter against a slot/cache model.
module tb_jt1943_rom_arbiter;

  localparam int unsigned SLOTS = 4;
  localparam int unsigned AW    = 22;
  localparam int unsigned DW    = 32;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [SLOTS-1:0]    slot_req = '0;
  logic [SLOTS*AW-1:0] slot_addr;
  logic [SLOTS-1:0]    slot_ok;
  logic [SLOTS*DW-1:0] slot_dout;
  logic                downloading = 1'b0;
  logic                loop_rst = 1'b0;
  logic                sdram_req;
  logic [AW-1:0]       sdram_addr;
  logic                sdram_ack = 1'b0;
  logic                data_rdy = 1'b0;
  logic [DW-1:0]       data_read = '0;
  logic                refresh_en;

  logic [AW-1:0] a [SLOTS];

  logic          mvalid [SLOTS];
  logic [AW-1:0] maddr  [SLOTS];
  logic [DW-1:0] mdata  [SLOTS];
  int            mptr;
  int            n_tests = 0;
  int            n_fail  = 0;

  always #5 clk = ~clk;

  always_comb
    for (int i = 0; i < SLOTS; i++) slot_addr[i*AW +: AW] = a[i];

  jt1943_rom_arbiter #(.SLOTS(SLOTS), .AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .slot_req    (slot_req),
    .slot_addr   (slot_addr),
    .slot_ok     (slot_ok),
    .slot_dout   (slot_dout),
    .downloading (downloading),
    .loop_rst    (loop_rst),
    .sdram_req   (sdram_req),
    .sdram_addr  (sdram_addr),
    .sdram_ack   (sdram_ack),
    .data_rdy    (data_rdy),
    .data_read   (data_read),
    .refresh_en  (refresh_en)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < SLOTS; i++) begin
      mvalid[i] = 1'b0;
      maddr[i]  = '0;
      mdata[i]  = '0;
    end
    mptr = SLOTS - 1;
  endtask

  task automatic model_fill(input int s, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    mvalid[s] = 1'b1;
    maddr[s]  = ad;
    mdata[s]  = d;
    mptr      = s;
  endtask

  function automatic int model_pick();
    for (int k = 1; k <= SLOTS; k++) begin
      int s;
      s = (mptr + k) % SLOTS;
      if (slot_req[s] && !(mvalid[s] && maddr[s] == a[s])) return s;
    end
    return -1;
  endfunction

  task automatic check_outputs(input string tag);
    logic [SLOTS-1:0] eo;
    for (int i = 0; i < SLOTS; i++)
      eo[i] = slot_req[i] && mvalid[i] && (maddr[i] == a[i]);
    chk({tag, "_ok"}, 64'(slot_ok), 64'(eo));
    for (int i = 0; i < SLOTS; i++)
      chk($sformatf("%s_dout%0d", tag, i), 64'(slot_dout[i*DW +: DW]), 64'(mdata[i]));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    slot_req = '0;
    sdram_ack = 1'b0;
    data_rdy = 1'b0;
    downloading = 1'b0;
    loop_rst = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Acts as jtgng_sdram for one fetch: waits for the request, acks, returns data.
  task automatic sdram_cycle(input string tag, input logic [AW-1:0] ea,
                             input logic [DW-1:0] d, input bit same);
    int n;
    n = 0;
    while (sdram_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req"}, 64'(sdram_req), 64'(1));
    chk({tag, "_addr"}, 64'(sdram_addr), 64'(ea));
    chk({tag, "_refresh"}, 64'(refresh_en), 64'(0));
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      chk({tag, "_stable"}, 64'(sdram_addr), 64'(ea));
    end
    sdram_ack = 1'b1;
    if (same) begin
      data_rdy  = 1'b1;
      data_read = d;
    end
    @(negedge clk);
    sdram_ack = 1'b0;
    if (!same) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      data_rdy  = 1'b1;
      data_read = d;
      @(negedge clk);
    end
    data_rdy = 1'b0;
  endtask

  task automatic model_step(input string tag);
    int s;
    logic [DW-1:0] d;
    s = model_pick();
    if (s < 0) begin
      @(negedge clk);
      chk({tag, "_noreq"}, 64'(sdram_req), 64'(0));
      chk({tag, "_refresh_idle"}, 64'(refresh_en), 64'(1));
    end else begin
      d = $urandom;
      sdram_cycle(tag, a[s], d, $urandom_range(0, 3) == 0);
      model_fill(s, a[s], d);
    end
    check_outputs(tag);
  endtask

  initial begin
    logic [DW-1:0] d;
    int n;
    for (int i = 0; i < SLOTS; i++) a[i] = '0;
    model_reset();

    // Reset values, with every slot requesting address 0 to expose stray valids.
    slot_req = '1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_req", 64'(sdram_req), 64'(0));
    chk("rst_addr", 64'(sdram_addr), 64'(0));
    chk("rst_refresh", 64'(refresh_en), 64'(1));
    chk("rst_ok", 64'(slot_ok), 64'(0));
    chk("rst_dout", 64'(slot_dout[63:0]), 64'(0));
    slot_req = '0;

    // Single miss, fill, then a same-address hit.
    @(negedge clk);
    a[1] = AW'(22'h00100);
    slot_req[1] = 1'b1;
    @(negedge clk);
    chk("t1_req_lat", 64'(sdram_req), 64'(1));
    sdram_cycle("t1", a[1], 32'hDEADBEEF, 1'b0);
    model_fill(1, a[1], 32'hDEADBEEF);
    chk("t1_ok", 64'(slot_ok[1]), 64'(1));
    chk("t1_dout", 64'(slot_dout[1*DW +: DW]), 64'(32'hDEADBEEF));
    slot_req[1] = 1'b0;
    @(negedge clk);
    slot_req[1] = 1'b1;
    #1;
    chk("t1_hit_same_cycle", 64'(slot_ok[1]), 64'(1));
    @(negedge clk);
    chk("t1_hit_noreq", 64'(sdram_req), 64'(0));

    // All slots missing: order 0,1,2,3 then 0 again.
    do_reset();
    for (int i = 0; i < SLOTS; i++) a[i] = AW'(32'h1000 + 32'(i) * 32'h10);
    slot_req = '1;
    for (int i = 0; i < SLOTS; i++) begin
      d = $urandom;
      sdram_cycle($sformatf("t2_slot%0d", i), a[i], d, 1'b0);
      model_fill(i, a[i], d);
    end
    check_outputs("t2_filled");
    a[0] = AW'(32'h1008);
    d = $urandom;
    sdram_cycle("t2_again0", a[0], d, 1'b0);
    model_fill(0, a[0], d);
    model_step("t2_allhit");

    // Address change during WAIT_DATA stores the latched address.
    do_reset();
    a[2] = AW'(32'h200);
    slot_req[2] = 1'b1;
    @(negedge clk);
    chk("t3_req", 64'(sdram_req), 64'(1));
    chk("t3_addr", 64'(sdram_addr), 64'(32'h200));
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    a[2] = AW'(32'h204);
    @(negedge clk);
    d = $urandom;
    data_rdy = 1'b1;
    data_read = d;
    @(negedge clk);
    data_rdy = 1'b0;
    model_fill(2, AW'(32'h200), d);
    chk("t3_ok_low", 64'(slot_ok[2]), 64'(0));
    check_outputs("t3_stale");
    model_step("t3_refetch");

    // downloading during WAIT_ACK drops the request and invalidates caches.
    do_reset();
    a[0] = AW'(32'h10);
    slot_req[0] = 1'b1;
    model_step("t4a");
    a[1] = AW'(32'h20);
    slot_req[1] = 1'b1;
    @(negedge clk);
    chk("t4_req", 64'(sdram_req), 64'(1));
    chk("t4_addr", 64'(sdram_addr), 64'(32'h20));
    mptr = 1;
    downloading = 1'b1;
    @(negedge clk);
    for (int i = 0; i < SLOTS; i++) mvalid[i] = 1'b0;
    chk("t4_req_drop", 64'(sdram_req), 64'(0));
    chk("t4_refresh", 64'(refresh_en), 64'(1));
    check_outputs("t4_invalid");
    downloading = 1'b0;
    model_step("t4b");
    model_step("t4c");

    // Same-cycle ack and data, then the next pending slot.
    a[2] = AW'(32'h300);
    a[3] = AW'(32'h310);
    slot_req[3:2] = 2'b11;
    d = $urandom;
    sdram_cycle("t5a", a[2], d, 1'b1);
    model_fill(2, a[2], d);
    chk("t5_idle", 64'(sdram_req), 64'(0));
    @(negedge clk);
    chk("t5_next_req", 64'(sdram_req), 64'(1));
    chk("t5_next_addr", 64'(sdram_addr), 64'(32'h310));
    model_step("t5b");

    // Asynchronous reset while in WAIT_DATA.
    a[1] = AW'(32'h120);
    n = 0;
    while (sdram_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t6_req", 64'(sdram_req), 64'(1));
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    check_outputs("t6_pre");
    #2 rst = 1'b1;
    #1;
    chk("t6_req_rst", 64'(sdram_req), 64'(0));
    chk("t6_refresh_rst", 64'(refresh_en), 64'(1));
    chk("t6_ok_rst", 64'(slot_ok), 64'(0));
    chk("t6_addr_rst", 64'(sdram_addr), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    slot_req = '0;

    // Randomized traffic with occasional loop_rst holds.
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < SLOTS; i++) begin
        if ($urandom_range(0, 3) == 0) slot_req[i] = ~slot_req[i];
        if ($urandom_range(0, 2) == 0)
          a[i] = AW'(32'(i + 1) * 32'h100 + 32'($urandom_range(0, 3)));
      end
      if ($urandom_range(0, 11) == 0) begin
        loop_rst = 1'b1;
        @(negedge clk);
        chk("rnd_loop_req", 64'(sdram_req), 64'(0));
        chk("rnd_loop_refresh", 64'(refresh_en), 64'(1));
        for (int i = 0; i < SLOTS; i++) mvalid[i] = 1'b0;
        loop_rst = 1'b0;
      end
      model_step($sformatf("rnd%0d", it));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
